smoothed_amplitude_mixer: RTL and testbench
===========================================

Name: smoothed_amplitude_mixer

Overview:
- Multi-channel successor to the single-channel amplitude modulator. Scales CHANNELS signed samples by per-channel amplitudes and sums them into a saturated mix.
- Each channel's applied gain slews toward its target, which removes zipper noise when an ADSR envelope or a volume control steps.
- One multiplier is time-shared across channels and driven by a per-frame sample strobe.
- Sits between the tone generators/envelope outputs and the DAC/PWM output stage.

Parameters:
- DATA_BITS, 12, sample width (signed two's complement).
- AMPLITUDE_BITS, 8, unsigned gain width; gain g means scale by g/2^AMPLITUDE_BITS.
- CHANNELS, 4, number of voices (1..16).
- RAMP_STEP, 4, maximum change in applied gain per frame. 0 means the gain jumps to the target immediately.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sample_stb  in  1  frame start; samples din and amplitude
- din  in  CHANNELS*DATA_BITS  packed signed samples; channel k at [k*DATA_BITS +: DATA_BITS]
- amplitude  in  CHANNELS*AMPLITUDE_BITS  packed target gains, same packing
- dout  out  CHANNELS*DATA_BITS  packed scaled samples
- mix  out  DATA_BITS  saturated signed sum of dout channels
- dout_valid  out  1  one-cycle pulse when dout/mix update
- busy  out  1  high while a frame is in progress
- overrun  out  1  one-cycle pulse when sample_stb arrives while busy

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE
  - all applied gains=0
  - dout=0, mix=0
  - dout_valid=0, busy=0, overrun=0
  - accumulator=0
  - Reset mid-frame aborts the frame; no dout_valid is produced.
- FSM states IDLE, RUN, FINISH:
  - IDLE: sample_stb at edge E0 snapshots din and amplitude into internal registers, clears the accumulator and sets ch=0. Next state RUN.
  - RUN: one channel per edge, E1..E(CHANNELS), ch = 0..CHANNELS-1. The last channel moves to FINISH.
  - FINISH: at edge E(CHANNELS+1), load the dout register and the saturated mix, pulse dout_valid, return to IDLE.
- busy is high in RUN and FINISH.
- Latency: dout_valid is high in the cycle after edge E(CHANNELS+1), i.e. CHANNELS+1 edges after sample_stb is sampled.
- Minimum strobe period is CHANNELS+2 cycles.
- sample_stb while busy:
  - ignored, with no effect on the frame;
  - overrun pulses for one cycle.
- Per-channel arithmetic in RUN (gain g = applied gain before this frame's slew):
  - product = din_k (signed) * {1'b0, g}. Width DATA_BITS+AMPLITUDE_BITS+1.
  - scaled_k = product >>> AMPLITUDE_BITS (arithmetic shift, floor rounding), truncated to DATA_BITS. It cannot overflow because g < 2^AMPLITUDE_BITS.
  - accumulator += sign-extended scaled_k. Accumulator width is DATA_BITS+clog2(CHANNELS)+1.
- Slew, in the same cycle, with target t = snapshot amplitude_k:
  - if RAMP_STEP=0, g' = t;
  - else if g < t, g' = min(g+RAMP_STEP, t);
  - else if g > t, g' = max(g-RAMP_STEP, t);
  - else g' = g.
  - There is no wrap-around; compute with one extra bit.
- mix in FINISH: clamp the accumulator to [-2^(DATA_BITS-1), 2^(DATA_BITS-1)-1].
- Between frames dout and mix hold their values. din and amplitude may change freely outside the strobe edge.

Decomposition:
- Shared package smoothed_amplitude_pkg:
  - state encoding localparams (IDLE/RUN/FINISH);
  - a clog2 constant function;
  - a saturate function (width-generic clamp).
- One natural sub-module: gain_slew. It is combinational next-gain logic parameterised by AMPLITUDE_BITS and RAMP_STEP, instantiated once on the muxed channel.
- The multiplier stays inline.

Test Plan (DATA_BITS=12, AMPLITUDE_BITS=8, CHANNELS=4):
- Scenario 1, RAMP_STEP=0, ch0 din=1000, amp=128, others amp=0; two frames:
  - Frame 1 gives dout0=0 (pre-slew gain 0).
  - Frame 2 gives dout0=500 and mix=500.
  - dout_valid appears exactly 5 edges after the strobe.
- Scenario 2, RAMP_STEP=4, ch1 amp target 20 from 0; frames 1..6:
  - Applied gain sequence 0,4,8,12,16,20, then holds at 20 (clamped, no overshoot).
  - Target dropped to 2: gain goes 16,12,8,4,2.
- Scenario 3, negative floor rounding:
  - din=-1, gain 255 gives dout=-1.
  - din=-2048, gain 128 gives -1024.
  - din=2047, gain 255 gives 2039.
- Scenario 4, saturation, RAMP_STEP=0, all channels din=2047, amp=255, settled frame:
  - each dout=2039; mix clamps to 2047.
  - all din=-2048: mix=-2048.
- Scenario 5, overrun: sample_stb 2 cycles after an accepted strobe:
  - overrun pulses once;
  - frame result unchanged;
  - exactly one dout_valid.
- Scenario 6, reset mid-frame: rst_n low during RUN (ch=2):
  - all outputs 0 immediately (async), state IDLE;
  - no dout_valid;
  - next strobe completes normally from gain 0.

Source files
------------

// File: rtl/smoothed_amplitude_pkg.sv
// Shared types and helpers for the smoothed amplitude mixer: FSM encoding,
// a constant clog2 and a width-generic signed clamp.
package smoothed_amplitude_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = 1; v < n; v = v << 1) begin
            r++;
        end
        return r;
    endfunction

    // Clamp val into the signed range of a bits-wide word (bits <= 31).
    function automatic logic signed [31:0] saturate(input logic signed [31:0] val,
                                                    input int unsigned bits);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (bits - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (bits - 1));
        if (val > hi) begin
            return hi;
        end
        if (val < lo) begin
            return lo;
        end
        return val;
    endfunction

endpackage

// File: rtl/smoothed_amplitude_mixer_gain_slew.sv
// Combinational next-gain: moves the applied gain toward the target by at most
// RAMP_STEP per frame, never overshooting or wrapping.
module gain_slew #(
    parameter int AMPLITUDE_BITS = 8,
    parameter int RAMP_STEP      = 4
) (
    input  logic [AMPLITUDE_BITS-1:0] i_gain,
    input  logic [AMPLITUDE_BITS-1:0] i_target,
    output logic [AMPLITUDE_BITS-1:0] o_gain
);

    localparam logic [AMPLITUDE_BITS:0] STEP = (AMPLITUDE_BITS + 1)'(RAMP_STEP);

    logic [AMPLITUDE_BITS:0] w_up;
    logic [AMPLITUDE_BITS:0] w_down;
    logic [AMPLITUDE_BITS:0] w_target_ext;

    assign w_up         = {1'b0, i_gain} + STEP;
    assign w_down       = {1'b0, i_gain} - STEP;
    assign w_target_ext = {1'b0, i_target};

    always_comb begin
        o_gain = i_gain;
        if (RAMP_STEP == 0) begin
            o_gain = i_target;
        end else if (i_gain < i_target) begin
            o_gain = (w_up > w_target_ext) ? i_target : w_up[AMPLITUDE_BITS-1:0];
        end else if (i_gain > i_target) begin
            // Top bit set means the subtraction went below zero.
            o_gain = (w_down[AMPLITUDE_BITS] || (w_down < w_target_ext)) ?
                     i_target : w_down[AMPLITUDE_BITS-1:0];
        end
    end

endmodule

// File: rtl/smoothed_amplitude_mixer.sv
// Multi-channel amplitude mixer: one time-shared multiplier scales each channel by
// its slewed gain, then the channels are summed into a saturated mix.
module smoothed_amplitude_mixer
    import smoothed_amplitude_pkg::*;
#(
    parameter int DATA_BITS      = 12,
    parameter int AMPLITUDE_BITS = 8,
    parameter int CHANNELS       = 4,
    parameter int RAMP_STEP      = 4
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_sample_stb,
    input  logic [CHANNELS*DATA_BITS-1:0]        i_din,
    input  logic [CHANNELS*AMPLITUDE_BITS-1:0]   i_amplitude,
    output logic [CHANNELS*DATA_BITS-1:0]        o_dout,
    output logic [DATA_BITS-1:0]                 o_mix,
    output logic                                 o_dout_valid,
    output logic                                 o_busy,
    output logic                                 o_overrun
);

    localparam int CH_BITS   = (CHANNELS > 1) ? clog2(CHANNELS) : 1;
    localparam int ACC_BITS  = DATA_BITS + clog2(CHANNELS) + 1;
    localparam int PROD_BITS = DATA_BITS + AMPLITUDE_BITS + 1;

    state_e                               r_state;
    state_e                               w_state_next;
    logic [CH_BITS-1:0]                   r_ch;
    logic [CHANNELS*DATA_BITS-1:0]        r_din_snap;
    logic [CHANNELS*DATA_BITS-1:0]        r_scaled;
    logic [CHANNELS*DATA_BITS-1:0]        r_dout;
    logic [CHANNELS*AMPLITUDE_BITS-1:0]   r_amp_snap;
    logic [CHANNELS*AMPLITUDE_BITS-1:0]   r_gain;
    logic signed [ACC_BITS-1:0]           r_acc;
    logic [DATA_BITS-1:0]                 r_mix;
    logic                                 r_dout_valid;
    logic                                 r_overrun;

    logic                                 w_busy;
    logic                                 w_last;
    logic signed [DATA_BITS-1:0]          w_din_k;
    logic signed [DATA_BITS-1:0]          w_scaled;
    logic [AMPLITUDE_BITS-1:0]            w_gain_k;
    logic [AMPLITUDE_BITS-1:0]            w_target_k;
    logic [AMPLITUDE_BITS-1:0]            w_gain_next;
    logic signed [AMPLITUDE_BITS:0]       w_gain_s;
    logic signed [PROD_BITS-1:0]          w_product;
    logic                                 w_unused_prod;

    assign w_busy     = (r_state != IDLE);
    assign w_last     = (r_ch == CH_BITS'(CHANNELS - 1));
    assign w_din_k    = r_din_snap[r_ch*DATA_BITS +: DATA_BITS];
    assign w_gain_k   = r_gain[r_ch*AMPLITUDE_BITS +: AMPLITUDE_BITS];
    assign w_target_k = r_amp_snap[r_ch*AMPLITUDE_BITS +: AMPLITUDE_BITS];
    assign w_gain_s   = {1'b0, w_gain_k};
    assign w_product  = w_din_k * w_gain_s;
    // Taking bits above the fraction is the floor-rounded arithmetic shift.
    assign w_scaled   = w_product[AMPLITUDE_BITS +: DATA_BITS];
    assign w_unused_prod = ^{w_product[AMPLITUDE_BITS-1:0], w_product[PROD_BITS-1]};

    gain_slew #(
        .AMPLITUDE_BITS (AMPLITUDE_BITS),
        .RAMP_STEP      (RAMP_STEP)
    ) u_gain_slew (
        .i_gain   (w_gain_k),
        .i_target (w_target_k),
        .o_gain   (w_gain_next)
    );

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (i_sample_stb) w_state_next = RUN;
            RUN:     if (w_last) w_state_next = FINISH;
            FINISH:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_ch         <= '0;
            r_din_snap   <= '0;
            r_amp_snap   <= '0;
            r_scaled     <= '0;
            r_gain       <= '0;
            r_acc        <= '0;
            r_dout       <= '0;
            r_mix        <= '0;
            r_dout_valid <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_dout_valid <= 1'b0;
            r_overrun    <= i_sample_stb && w_busy;
            unique case (r_state)
                IDLE: begin
                    if (i_sample_stb) begin
                        r_din_snap <= i_din;
                        r_amp_snap <= i_amplitude;
                        r_acc      <= '0;
                        r_ch       <= '0;
                    end
                end
                RUN: begin
                    r_scaled[r_ch*DATA_BITS +: DATA_BITS]          <= w_scaled;
                    r_gain[r_ch*AMPLITUDE_BITS +: AMPLITUDE_BITS]  <= w_gain_next;
                    r_acc <= r_acc + ACC_BITS'(w_scaled);
                    r_ch  <= r_ch + CH_BITS'(1);
                end
                FINISH: begin
                    r_dout       <= r_scaled;
                    r_mix        <= DATA_BITS'(saturate(32'(r_acc), DATA_BITS));
                    r_dout_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_dout       = r_dout;
    assign o_mix        = r_mix;
    assign o_dout_valid = r_dout_valid;
    assign o_busy       = w_busy;
    assign o_overrun    = r_overrun;

endmodule

// File: tb/tb_smoothed_amplitude_mixer.sv
// Directed and randomized frames applied to two mixers (instant and ramped gain),
// checked against an arithmetic reference model.
module tb_smoothed_amplitude_mixer;

    localparam int DB = 12;
    localparam int AB = 8;
    localparam int CH = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            stb;
    logic [CH*DB-1:0] din;
    logic [CH*AB-1:0] amp;
    logic [CH*DB-1:0] dout0, dout4;
    logic [DB-1:0]    mix0, mix4;
    logic            v0, v4, b0, b4, o0, o4;

    int vectors     = 0;
    int miscompares = 0;

    int m_din[CH];
    int m_amp[CH];
    int mg0[CH];
    int mg4[CH];
    int ex0[CH];
    int ex4[CH];
    int exm0, exm4;

    always #5 clk = ~clk;

    smoothed_amplitude_mixer #(
        .DATA_BITS(DB), .AMPLITUDE_BITS(AB), .CHANNELS(CH), .RAMP_STEP(0)
    ) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_sample_stb(stb), .i_din(din), .i_amplitude(amp),
        .o_dout(dout0), .o_mix(mix0), .o_dout_valid(v0), .o_busy(b0), .o_overrun(o0)
    );

    smoothed_amplitude_mixer #(
        .DATA_BITS(DB), .AMPLITUDE_BITS(AB), .CHANNELS(CH), .RAMP_STEP(4)
    ) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_sample_stb(stb), .i_din(din), .i_amplitude(amp),
        .o_dout(dout4), .o_mix(mix4), .o_dout_valid(v4), .o_busy(b4), .o_overrun(o4)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int floor_div256(input int q);
        if (q >= 0) return q / 256;
        return -((-q + 255) / 256);
    endfunction

    function automatic int clamp_mix(input int v);
        if (v > 2047) return 2047;
        if (v < -2048) return -2048;
        return v;
    endfunction

    function automatic int slew(input int g, input int t, input int step);
        if (step == 0) return t;
        if (g < t) return (g + step < t) ? g + step : t;
        if (g > t) return (g - step > t) ? g - step : t;
        return g;
    endfunction

    task automatic model_frame();
        int s0, s4;
        s0 = 0;
        s4 = 0;
        for (int k = 0; k < CH; k++) begin
            ex0[k] = floor_div256(m_din[k] * mg0[k]);
            ex4[k] = floor_div256(m_din[k] * mg4[k]);
            s0 += ex0[k];
            s4 += ex4[k];
            mg0[k] = slew(mg0[k], m_amp[k], 0);
            mg4[k] = slew(mg4[k], m_amp[k], 4);
        end
        exm0 = clamp_mix(s0);
        exm4 = clamp_mix(s4);
    endtask

    task automatic drive_bus();
        for (int k = 0; k < CH; k++) begin
            din[k*DB +: DB] = DB'(m_din[k]);
            amp[k*AB +: AB] = AB'(m_amp[k]);
        end
    endtask

    task automatic set_all(input int d, input int a);
        for (int k = 0; k < CH; k++) begin
            m_din[k] = d;
            m_amp[k] = a;
        end
    endtask

    // Strobe one frame; ovr_at > 0 injects a second strobe that many cycles later.
    task automatic run_frame(input string tag, input int ovr_at);
        int first_v, nv0, nv4, no0, no4;
        first_v = 0;
        nv0 = 0;
        nv4 = 0;
        no0 = 0;
        no4 = 0;
        model_frame();
        drive_bus();
        stb = 1'b1;
        @(posedge clk);
        #1;
        stb = 1'b0;
        check({tag, "_busy"}, 32'(b0), 1);
        for (int c = 1; c <= 8; c++) begin
            if (ovr_at > 0 && c - 1 == ovr_at) begin
                stb = 1'b1;
                din = ~din;
            end else begin
                stb = 1'b0;
            end
            @(posedge clk);
            #1;
            if (v0 && first_v == 0) first_v = c;
            nv0 += int'(v0);
            nv4 += int'(v4);
            no0 += int'(o0);
            no4 += int'(o4);
        end
        stb = 1'b0;
        check({tag, "_latency"}, first_v, 5);
        check({tag, "_valid_cnt0"}, nv0, 1);
        check({tag, "_valid_cnt4"}, nv4, 1);
        check({tag, "_overrun0"}, no0, (ovr_at > 0) ? 1 : 0);
        check({tag, "_overrun4"}, no4, (ovr_at > 0) ? 1 : 0);
        check({tag, "_idle"}, 32'(b0), 0);
        for (int k = 0; k < CH; k++) begin
            check($sformatf("%s_dout0_ch%0d", tag, k), $signed(dout0[k*DB +: DB]), ex0[k]);
            check($sformatf("%s_dout4_ch%0d", tag, k), $signed(dout4[k*DB +: DB]), ex4[k]);
        end
        check({tag, "_mix0"}, $signed(mix0), exm0);
        check({tag, "_mix4"}, $signed(mix4), exm4);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dout0"}, 32'(dout0 != '0), 0);
        check({tag, "_dout4"}, 32'(dout4 != '0), 0);
        check({tag, "_mix0"}, $signed(mix0), 0);
        check({tag, "_mix4"}, $signed(mix4), 0);
        check({tag, "_flags"}, 32'({v0, v4, b0, b4, o0, o4}), 0);
    endtask

    int seq_up[7] = '{0, 4, 8, 12, 16, 20, 20};
    int seq_dn[6] = '{20, 16, 12, 8, 4, 2};

    initial begin
        int nv;
        rst_n = 1'b0;
        stb   = 1'b0;
        din   = '0;
        amp   = '0;
        for (int k = 0; k < CH; k++) begin
            mg0[k] = 0;
            mg4[k] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Instant gain: first frame uses the pre-slew gain of 0.
        set_all(0, 0);
        m_din[0] = 1000;
        m_amp[0] = 128;
        run_frame("s1_f1", 0);
        check("s1_f1_const", $signed(dout0[DB-1:0]), 0);
        run_frame("s1_f2", 0);
        check("s1_f2_const", $signed(dout0[DB-1:0]), 500);
        check("s1_f2_mix", $signed(mix0), 500);

        // Ramped gain on ch1, observed through din=1024 (dout = 4*gain).
        set_all(0, 0);
        m_din[1] = 1024;
        m_amp[1] = 20;
        for (int f = 0; f < 7; f++) begin
            run_frame($sformatf("s2_up%0d", f), 0);
            check($sformatf("s2_up%0d_gain", f), $signed(dout4[DB +: DB]), 4 * seq_up[f]);
        end
        m_amp[1] = 2;
        for (int f = 0; f < 6; f++) begin
            run_frame($sformatf("s2_dn%0d", f), 0);
            check($sformatf("s2_dn%0d_gain", f), $signed(dout4[DB +: DB]), 4 * seq_dn[f]);
        end

        // Floor rounding of negative products.
        m_din = '{-1, -2048, 2047, 0};
        m_amp = '{255, 128, 255, 0};
        run_frame("s3_f1", 0);
        run_frame("s3_f2", 0);
        check("s3_neg1", $signed(dout0[0 +: DB]), -1);
        check("s3_neg2048", $signed(dout0[DB +: DB]), -1024);
        check("s3_pos2047", $signed(dout0[2*DB +: DB]), 2039);

        // Saturation in both directions.
        set_all(2047, 255);
        run_frame("s4_p1", 0);
        run_frame("s4_p2", 0);
        check("s4_pos_dout", $signed(dout0[3*DB +: DB]), 2039);
        check("s4_pos_mix", $signed(mix0), 2047);
        set_all(-2048, 255);
        run_frame("s4_n1", 0);
        check("s4_neg_mix", $signed(mix0), -2048);

        for (int f = 0; f < 20; f++) begin
            for (int k = 0; k < CH; k++) begin
                m_din[k] = int'($urandom_range(0, 4095)) - 2048;
                m_amp[k] = int'($urandom_range(0, 255));
            end
            run_frame($sformatf("rnd%0d", f), 0);
        end

        // Strobe while busy: ignored, flagged once.
        run_frame("s5_ovr", 2);
        run_frame("s5_after", 0);

        // Asynchronous reset in RUN with ch=2.
        for (int k = 0; k < CH; k++) begin
            m_din[k] = 500 + 100 * k;
            m_amp[k] = 200;
        end
        drive_bus();
        stb = 1'b1;
        @(posedge clk);
        #1;
        stb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("s6_reset");
        for (int k = 0; k < CH; k++) begin
            mg0[k] = 0;
            mg4[k] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        nv = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            nv += int'(v0) + int'(v4);
        end
        check("s6_no_valid", nv, 0);
        run_frame("s6_f1", 0);
        run_frame("s6_f2", 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
